// File: rtl/riscv_trace_pkg.sv
// Shared types for the retire trace path: one formatted retire event per FIFO entry.
package riscv_trace_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int TRACE_SEQ_W = 16;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        instr;
    logic [REG_ADDR_W-1:0]  rd;
    logic                   we;
    logic [XLEN-1:0]        wdata;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_entry_t;

  // Writes to x0 are architecturally invisible, so they are traced as no-write with zero data.
  function automatic trace_entry_t format_entry(
    input logic [XLEN-1:0]        pc,
    input logic [XLEN-1:0]        instr,
    input logic [REG_ADDR_W-1:0]  rd,
    input logic                   reg_write,
    input logic [XLEN-1:0]        wdata,
    input logic [TRACE_SEQ_W-1:0] seq
  );
    trace_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.rd    = rd;
    e.we    = reg_write && (rd != '0);
    e.wdata = (rd == '0) ? '0 : wdata;
    e.seq   = seq;
    return e;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// Generic single-clock FIFO of trace entries; pointers carry one extra wrap bit.
module trace_sync_fifo
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  trace_entry_t               wdata,
  output trace_entry_t               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  trace_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[IDX_W-1:0]];

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: formats writeback events, sequences them, and streams them out via a FIFO.
module retire_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int STALL_MARGIN = 2,
  parameter int SEQ_W        = TRACE_SEQ_W,
  parameter int DROP_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  input  logic [XLEN-1:0]         wb_pc,
  input  logic [XLEN-1:0]         wb_instr,
  input  logic [REG_ADDR_W-1:0]   wb_rd,
  input  logic                    wb_reg_write,
  input  logic [XLEN-1:0]         wb_wdata,
  input  logic                    clear,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [XLEN-1:0]         trace_pc,
  output logic [XLEN-1:0]         trace_instr,
  output logic [REG_ADDR_W-1:0]   trace_rd,
  output logic                    trace_we,
  output logic [XLEN-1:0]         trace_wdata,
  output logic [SEQ_W-1:0]        trace_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    stall_req,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  trace_entry_t      wr_entry, head_entry;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, count_next;
  logic              pop, push, drop;

  logic [SEQ_W-1:0]  seq_next_q, seq_next_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;
  logic              stall_req_q, stall_req_d;

  assign pop  = !fifo_empty && trace_ready;
  assign push = wb_valid && !clear && (!fifo_full || pop);
  assign drop = wb_valid && !clear && fifo_full && !pop;

  assign wr_entry = format_entry(wb_pc, wb_instr, wb_rd, wb_reg_write, wb_wdata,
                                 TRACE_SEQ_W'(seq_next_q));

  trace_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    seq_next_d   = wb_valid ? seq_next_q + SEQ_W'(1) : seq_next_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    count_next   = fifo_count + CNT_W'(push) - CNT_W'(pop);
    if (clear) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
      count_next   = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + DROP_W'(1);
    end
    // Registered so the hazard unit sees a clean flop output; the margin covers its latency.
    stall_req_d = (count_next >= CNT_W'(DEPTH - STALL_MARGIN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_next_q   <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      stall_req_q  <= 1'b0;
    end else begin
      seq_next_q   <= seq_next_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      stall_req_q  <= stall_req_d;
    end
  end

  assign trace_valid = !fifo_empty;
  assign trace_pc    = trace_valid ? head_entry.pc    : '0;
  assign trace_instr = trace_valid ? head_entry.instr : '0;
  assign trace_rd    = trace_valid ? head_entry.rd    : '0;
  assign trace_we    = trace_valid ? head_entry.we    : 1'b0;
  assign trace_wdata = trace_valid ? head_entry.wdata : '0;
  assign trace_seq   = trace_valid ? SEQ_W'(head_entry.seq) : '0;
  assign count       = fifo_count;
  assign stall_req   = stall_req_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: queue-based reference model plus an output monitor.
module tb_retire_trace_buffer;
  import riscv_trace_pkg::*;

  localparam int DEPTH        = 8;
  localparam int STALL_MARGIN = 2;
  localparam int SEQ_W        = 16;
  localparam int DROP_W       = 8;
  localparam int DROP_MAX     = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic [31:0]       wb_pc, wb_instr, wb_wdata;
  logic [4:0]        wb_rd;
  logic              wb_reg_write;
  logic              clear;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_pc, trace_instr, trace_wdata;
  logic [4:0]        trace_rd;
  logic              trace_we;
  logic [SEQ_W-1:0]  trace_seq;
  logic [$clog2(DEPTH):0] count;
  logic              stall_req;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  retire_trace_buffer #(
    .DEPTH(DEPTH), .STALL_MARGIN(STALL_MARGIN), .SEQ_W(SEQ_W), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_wdata(wb_wdata), .clear(clear),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_rd(trace_rd),
    .trace_we(trace_we), .trace_wdata(trace_wdata), .trace_seq(trace_seq),
    .count(count), .stall_req(stall_req), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, expected stream contents and status, updated per clock edge.
  trace_entry_t     sb_q[$];
  trace_entry_t     exp_e;
  trace_entry_t     dut_head;
  int               occ     = 0;
  int               m_dc    = 0;
  logic [SEQ_W-1:0] m_seq   = '0;
  logic             m_ovf   = 1'b0;
  logic             m_stall = 1'b0;
  bit               m_pop, m_push;
  bit               mon_en  = 1'b0;

  assign dut_head = {trace_pc, trace_instr, trace_rd, trace_we, trace_wdata, trace_seq};

  always @(posedge clk) begin
    if (rst) begin
      occ = 0; sb_q.delete(); m_seq = '0; m_ovf = 1'b0; m_dc = 0; m_stall = 1'b0;
      mon_en = 1'b1;
    end else begin
      if (clear) begin
        occ = 0; sb_q.delete(); m_ovf = 1'b0; m_dc = 0;
      end else begin
        m_pop  = (occ > 0) && trace_ready;
        m_push = wb_valid && ((occ < DEPTH) || m_pop);
        if (m_push) begin
          exp_e.pc    = wb_pc;
          exp_e.instr = wb_instr;
          exp_e.rd    = wb_rd;
          exp_e.we    = wb_reg_write && (wb_rd != 0);
          exp_e.wdata = (wb_rd == 0) ? 32'h0 : wb_wdata;
          exp_e.seq   = m_seq;
          sb_q.push_back(exp_e);
        end else if (wb_valid) begin
          m_ovf = 1'b1;
          if (m_dc < DROP_MAX) m_dc++;
        end
        occ = occ - int'(m_pop) + int'(m_push);
      end
      if (wb_valid) m_seq = m_seq + 16'd1;
      m_stall = (occ >= DEPTH - STALL_MARGIN);
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each accepted head.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", count, occ);
      check("trace_valid", trace_valid, occ > 0);
      check("stall_req", stall_req, m_stall);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_dc);
      if (trace_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_head: actual=%0h expected=none at %0t", dut_head, $time);
        end else begin
          check("head_entry", dut_head, sb_q[0]);
          if (trace_ready) void'(sb_q.pop_front());
        end
      end else begin
        check("idle_outputs_zero", dut_head, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wb_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic we, input logic [31:0] wd);
    wb_valid = 1'b1; wb_pc = pc; wb_instr = instr; wb_rd = rd; wb_reg_write = we; wb_wdata = wd;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic retire_rand();
    logic [4:0] rd;
    rd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
    retire($urandom, $urandom, rd, 1'($urandom), $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wb_valid = 1'b0; trace_ready = 1'b0;
    wb_pc = '0; wb_instr = '0; wb_rd = '0; wb_reg_write = 1'b0; wb_wdata = '0;
    step(); step();
    rst = 1'b0;

    // Single retire with a ready consumer.
    trace_ready = 1'b1;
    retire(32'h0000_0010, 32'h0050_0093, 5'd1, 1'b1, 32'd5);
    @(negedge clk);
    check("t1_valid", trace_valid, 1'b1);
    check("t1_pc", trace_pc, 32'h10);
    check("t1_wdata", trace_wdata, 32'd5);
    check("t1_seq", trace_seq, 16'd0);
    step();
    @(negedge clk);
    check("t1_count_back", count, 0);

    // Write to x0 is filtered.
    retire(32'h0000_0014, 32'h0000_0013, 5'd0, 1'b1, 32'h1234);
    @(negedge clk);
    check("t2_we", trace_we, 1'b0);
    check("t2_wdata", trace_wdata, 32'h0);
    idle(2);

    // Fill with no consumer: stall threshold, full, then two drops.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      retire_rand();
      if (i == 4) begin @(negedge clk); check("t3_stall_below", stall_req, 1'b0); end
      if (i == 5) begin @(negedge clk); check("t3_stall_at", stall_req, 1'b1); end
    end
    @(negedge clk);
    check("t3_count_full", count, DEPTH);
    check("t3_overflow", overflow, 1'b1);
    check("t3_drops", drop_count, 8'd2);
    trace_ready = 1'b1;
    idle(8);
    trace_ready = 1'b0;
    retire_rand();
    @(negedge clk);
    check("t3_seq_after_gap", trace_seq, 16'd10);
    trace_ready = 1'b1;
    idle(2);

    // Full with simultaneous push and pop.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) retire_rand();
    trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) retire_rand();
    @(negedge clk);
    check("t4_count_full", count, DEPTH);
    check("t4_no_drop", drop_count, 8'd0);
    idle(DEPTH + 2);

    // Clear together with a retire while 3 entries are held.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) retire_rand();
    clear = 1'b1;
    retire_rand();
    clear = 1'b0;
    @(negedge clk);
    check("t5_count", count, 0);
    retire_rand();
    @(negedge clk);
    check("t5_seq", trace_seq, 16'd4);

    // Reset mid-stream with 5 entries held.
    do_reset();
    for (int i = 0; i < 5; i++) retire_rand();
    rst = 1'b1;
    retire_rand();
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid", trace_valid, 1'b0);
    check("t6_count", count, 0);
    retire_rand();
    @(negedge clk);
    check("t6_seq", trace_seq, 16'd0);

    // Drop counter saturation, then clear of status.
    for (int i = 0; i < DEPTH - 1 + 300; i++) retire_rand();
    @(negedge clk);
    check("sat_drop_count", drop_count, 8'd255);
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    check("sat_cleared_drop", drop_count, 8'd0);
    check("sat_cleared_ovf", overflow, 1'b0);

    // Random traffic, long enough for the sequence number to wrap.
    for (int i = 0; i < 76000; i++) begin
      wb_valid     = ($urandom_range(7) != 0);
      wb_pc        = $urandom;
      wb_instr     = $urandom;
      wb_rd        = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      wb_reg_write = 1'($urandom);
      wb_wdata     = $urandom;
      trace_ready  = 1'($urandom);
      clear        = ($urandom_range(1023) == 0);
      step();
    end
    clear = 1'b0;
    trace_ready = 1'b1;
    idle(DEPTH + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Sits directly downstream of the writeback stage of the 5-stage RISC-V pipeline.
- Captures one retire event per cycle: PC, instruction, destination register, write enable and write data.
- Holds the events in a FIFO and presents them on a valid/ready stream to the verification monitor or debug port.
- Provides backpressure to the core hazard unit, plus drop/overflow status.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of two and at least 4.
- STALL_MARGIN, 2: `stall_req` asserts when occupancy is at least DEPTH-STALL_MARGIN.
- SEQ_W, 16: width of the retire sequence number.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- wb_valid  in  1  an instruction retires this cycle.
- wb_pc  in  32  PC of the retiring instruction.
- wb_instr  in  32  instruction word.
- wb_rd  in  5  destination register index.
- wb_reg_write  in  1  register-file write enable.
- wb_wdata  in  32  register write data.
- clear  in  1  synchronous flush of buffer contents and status.
- trace_valid  out  1  head entry is available.
- trace_ready  in  1  consumer accepts the head entry.
- trace_pc  out  32  head PC.
- trace_instr  out  32  head instruction.
- trace_rd  out  5  head destination register.
- trace_we  out  1  head effective write enable.
- trace_wdata  out  32  head write data.
- trace_seq  out  SEQ_W  head retire sequence number.
- count  out  $clog2(DEPTH)+1  current occupancy.
- stall_req  out  1  almost-full backpressure to the hazard unit.
- overflow  out  1  sticky flag: an event was dropped.
- drop_count  out  DROP_W  saturating count of dropped events.

Behaviour:
- Reset (rst=1 at a clock edge) clears all of the following to 0: pointers, `count`, `trace_valid`, `stall_req`, `overflow`, `drop_count`, and the internal sequence counter `seq_next`. Storage array contents are not reset.
- Reset asserted mid-stream discards all buffered entries. No partial handshake survives reset.
- Handshake:
  - A pop occurs when `trace_valid` and `trace_ready` are both 1.
  - Head data is stable while `trace_valid`=1 and `trace_ready`=0.
  - All `trace_*` data outputs read 0 when `trace_valid`=0.
- Latency: an event accepted at edge N appears at the head no earlier than after edge N; `trace_valid` is 1 in cycle N+1 if the FIFO was empty. There is no same-cycle bypass.
- Push condition: `wb_valid` && (!full || pop this cycle). A push and a pop in the same cycle leave `count` unchanged. When full, a simultaneous pop makes room for the push.
- Drop condition: `wb_valid` && full && no pop.
  - Entry is discarded.
  - `overflow` sets, and stays set until `rst` or `clear`.
  - `drop_count` increments and saturates at 2^DROP_W-1.
- Sequence numbering:
  - `seq_next` increments by 1 on every `wb_valid`, including dropped events.
  - Gaps in `trace_seq` therefore identify drops.
  - Wraps modulo 2^SEQ_W.
  - The stored seq is the value of `seq_next` before the increment.
- x0 filtering: stored `trace_we` = `wb_reg_write` && (`wb_rd`!=0). When `wb_rd`=0, `trace_wdata` is stored as 0.
- `stall_req` is registered: value at cycle N+1 = (`count` after edge N) >= DEPTH-STALL_MARGIN.
- `clear`:
  - Empties the FIFO and zeroes `overflow` and `drop_count` the same edge.
  - `seq_next` is preserved.
  - `clear` takes priority over a simultaneous push and pop: the incoming event is discarded without counting as a drop, but `seq_next` still increments.
  - `rst` takes priority over `clear`.
- Pointers are $clog2(DEPTH)+1 bits. full = MSBs differ and the index bits are equal; empty = pointers equal. Wrap-around is natural modulo 2·DEPTH.

Decomposition:
- Shared package `riscv_trace_pkg`:
  - `trace_entry_t` packed struct {pc[31:0], instr[31:0], rd[4:0], we, wdata[31:0], seq[SEQ_W-1:0]}.
  - `XLEN`=32 and `REG_ADDR_W`=5 constants.
- One natural sub-module: `trace_sync_fifo`, a generic single-clock FIFO of `trace_entry_t` with push/pop/full/empty/count.
- The top level contains the entry formatting, sequence counter, drop/overflow logic, `stall_req` register and output zeroing.

Test Plan (DEPTH=8, STALL_MARGIN=2):
1. Single retire: `wb_valid` pc=0x00000010, instr=0x00500093, rd=1, we=1, wdata=5, with `trace_ready`=1 → `trace_valid` high exactly one cycle later with the same fields and seq=0; `count` returns to 0.
2. x0 write: retire instr 0x00000013 with rd=0, we=1, wdata=0x1234 → `trace_we`=0 and `trace_wdata`=0.
3. Fill with `trace_ready`=0: 6 retires → `stall_req`=1 in the cycle after the 6th; 8 retires → `count`=8; 2 more retires → `overflow`=1, `drop_count`=2. Draining then yields seq 0..7, and the next accepted retire has seq=10.
4. Full with simultaneous push and pop (`trace_ready`=1, `wb_valid`=1) → `count` stays 8, no drop, output order preserved.
5. `clear` asserted together with `wb_valid` while 3 entries are held → `count`=0, `overflow`=0, `drop_count`=0 next cycle; the following retire carries seq=4.
6. `rst` asserted mid-stream with 5 entries held → all outputs 0 next cycle; next retire has seq=0. Also: `drop_count` saturates at 255 after 300 drops; seq wraps from 0xFFFF to 0x0000.
